// File: rtl/reqgnt_pkg.sv
// Shared types and helpers for the round-robin req/gnt arbiter.
package reqgnt_pkg;

    // Arbiter control states. GAP is the single idle cycle forced between grants.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    // Width of an index into n requesters, never less than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Width of a counter that must be able to hold the value max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val <= 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/reqgnt_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module reqgnt_rr_pick
    import reqgnt_pkg::*;
#(
    parameter int N = 4,
    parameter int W = idx_width(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic         valid_o,
    output logic [W-1:0] idx_o
);

    // The request vector is duplicated so that shifting right by ptr rotates
    // it: bit k of the low half then corresponds to requester (ptr + k) mod N.
    logic [2*N-1:0] dbl_req;
    logic [N-1:0]   rot_req;
    logic [W-1:0]   offset;
    logic [W:0]     sum;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_dup
            assign dbl_req[gi]     = req_i[gi];
            assign dbl_req[gi + N] = req_i[gi];
        end
    endgenerate

    assign rot_req = N'(dbl_req >> ptr_i);

    // Lowest set bit of the rotated vector, then map back to an absolute index.
    always_comb begin
        offset = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot_req[k]) begin
                offset = W'(k);
            end
        end
        sum = {1'b0, ptr_i} + {1'b0, offset};
        if (sum >= (W + 1)'(N)) begin
            sum = sum - (W + 1)'(N);
        end
        valid_o = |req_i;
        idx_o   = sum[W-1:0];
    end

endmodule

// File: rtl/reqgnt_arbiter.sv
// Round-robin arbiter with bounded grant hold time and a one-cycle gap
// between consecutive grants.
module reqgnt_arbiter
    import reqgnt_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N-1:0]           req,
    output logic [N-1:0]           gnt,
    output logic                   busy,
    output logic [idx_width(N)-1:0] owner,
    output logic                   expired
);

    localparam int W  = idx_width(N);
    localparam int CW = cnt_width(MAX_HOLD);
    localparam logic [CW-1:0] HOLD_LIMIT = CW'(MAX_HOLD);
    localparam logic [W-1:0]  LAST_IDX   = W'(N - 1);

    arb_state_t     state_q;
    logic [W-1:0]   ptr_q;
    logic [CW-1:0]  count_q;
    logic [N-1:0]   gnt_q;
    logic           busy_q;
    logic [W-1:0]   owner_q;
    logic           expired_q;

    logic           pick_valid;
    logic [W-1:0]   pick_idx;
    logic           release_d;
    logic [W-1:0]   ptr_d;

    reqgnt_rr_pick #(
        .N (N),
        .W (W)
    ) u_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    // Grant ends when its owner lets go or the hold budget is used up;
    // the pointer then moves just past the owner so it re-competes last.
    always_comb begin
        release_d = !req[owner_q] || (count_q == HOLD_LIMIT);
        ptr_d     = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
    end

    // Arbitration FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            count_q   <= '0;
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            owner_q   <= '0;
            expired_q <= 1'b0;
        end else begin
            expired_q <= 1'b0;
            case (state_q)
                IDLE, GAP: begin
                    if (pick_valid) begin
                        gnt_q   <= N'(1) << pick_idx;
                        owner_q <= pick_idx;
                        busy_q  <= 1'b1;
                        count_q <= CW'(1);
                        state_q <= GRANT;
                    end else begin
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                GRANT: begin
                    if (release_d) begin
                        gnt_q     <= '0;
                        busy_q    <= 1'b0;
                        ptr_q     <= ptr_d;
                        count_q   <= '0;
                        expired_q <= req[owner_q];
                        state_q   <= GAP;
                    end else if (count_q != HOLD_LIMIT) begin
                        count_q <= count_q + 1'b1;
                    end
                end
                default: begin
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign busy    = busy_q;
    assign owner   = owner_q;
    assign expired = expired_q;

endmodule

// File: tb/tb_reqgnt_arbiter.sv
// Scoreboard bench for reqgnt_arbiter: a per-cycle behavioural model pushes
// expected outputs, a monitor pops and compares them after each clock edge.
module tb_reqgnt_arbiter;

    localparam int N        = 4;
    localparam int W        = 2;
    localparam int MAX_HOLD = 8;
    localparam int FAIR_BOUND = (N - 1) * (MAX_HOLD + 1) + 1;

    typedef struct packed {
        logic [N-1:0] gnt;
        logic         busy;
        logic [W-1:0] owner;
        logic         expired;
    } exp_t;

    logic         clk;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic         busy;
    logic [W-1:0] owner;
    logic         expired;

    int tests_run = 0;
    int tests_failed = 0;
    int cycle_no = 0;

    exp_t exp_q[$];

    // Model state: who holds the resource and for how many cycles so far.
    bit  m_granted = 0;
    int  m_owner = 0;
    int  m_ptr = 0;
    int  m_held = 0;

    reqgnt_arbiter #(
        .N        (N),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .gnt     (gnt),
        .busy    (busy),
        .owner   (owner),
        .expired (expired)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    // Drive one cycle of inputs and push what the outputs must become.
    task automatic step(input logic r, input logic [N-1:0] q);
        exp_t e;
        int   found;
        e = '0;
        if (!r) begin
            m_granted = 0; m_owner = 0; m_ptr = 0; m_held = 0;
        end else if (m_granted) begin
            if (!q[m_owner] || m_held == MAX_HOLD) begin
                e.expired = q[m_owner];
                m_granted = 0;
                m_ptr     = (m_owner + 1) % N;
                m_held    = 0;
            end else begin
                m_held++;
                e.gnt  = N'(1) << m_owner;
                e.busy = 1'b1;
            end
        end else begin
            found = -1;
            for (int k = 0; k < N; k++) begin
                if (found < 0 && q[(m_ptr + k) % N]) found = (m_ptr + k) % N;
            end
            if (found >= 0) begin
                m_granted = 1;
                m_owner   = found;
                m_held    = 1;
                e.gnt     = N'(1) << found;
                e.busy    = 1'b1;
            end
        end
        e.owner = W'(m_owner);
        rst = r;
        req = q;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: compare against the scoreboard and check invariants.
    logic [N-1:0] req_s;
    logic         rst_s;
    logic [N-1:0] gnt_prev = '0;
    int           wait_cnt [N];

    always @(posedge clk) begin
        exp_t e;
        req_s = req;
        rst_s = rst;
        #1;
        cycle_no++;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if ({gnt, busy, owner, expired} !== e) begin
                tests_failed++;
                $display("[TB] FAIL outputs cycle %0d: got gnt=%b busy=%b owner=%0d expired=%b, want gnt=%b busy=%b owner=%0d expired=%b",
                         cycle_no, gnt, busy, owner, expired, e.gnt, e.busy, e.owner, e.expired);
            end
            if (gnt != '0 && gnt_prev == '0) begin
                $display("[TB] grant owner=%0d cycle %0d", owner, cycle_no);
            end
        end
        tests_run++;
        if (!$onehot0(gnt)) begin
            tests_failed++;
            $display("[TB] FAIL onehot cycle %0d: got gnt=%b, want at most one bit", cycle_no, gnt);
        end
        for (int i = 0; i < N; i++) begin
            if (gnt[i] && !gnt_prev[i]) begin
                tests_run++;
                if (!req_s[i]) begin
                    tests_failed++;
                    $display("[TB] FAIL gnt_without_req cycle %0d: got gnt[%0d]=1, want req[%0d]=1 sampled", cycle_no, i, i);
                end
            end
            if (!rst_s || !req_s[i] || gnt[i]) wait_cnt[i] = 0;
            else wait_cnt[i]++;
            if (wait_cnt[i] > FAIR_BOUND) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL fairness req %0d: got wait=%0d, want <=%0d", i, wait_cnt[i], FAIR_BOUND);
                wait_cnt[i] = 0;
            end
        end
        gnt_prev = gnt;
    end

    initial begin
        logic [N-1:0] rv;
        int           dur;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        rst = 1'b0;
        req = '0;
        @(negedge clk);
        // Reset held with all requests asserted.
        step(1'b0, 4'b1111);
        step(1'b0, 4'b1111);
        // Single requester, short hold, then release.
        repeat (3) step(1'b1, 4'b0100);
        repeat (3) step(1'b1, 4'b0000);
        // Everyone requesting: timeouts and rotation.
        repeat (45) step(1'b1, 4'b1111);
        repeat (3) step(1'b1, 4'b0000);
        // Request dropped in the cycle the hold limit is reached.
        repeat (8) step(1'b1, 4'b0001);
        step(1'b1, 4'b0000);
        repeat (4) step(1'b1, 4'b1111);
        repeat (3) step(1'b1, 4'b0000);
        // Reset in the middle of requester 3's grant.
        repeat (2) step(1'b1, 4'b1000);
        repeat (2) step(1'b1, 4'b1010);
        step(1'b0, 4'b1010);
        repeat (12) step(1'b1, 4'b1010);
        // Randomised traffic with occasional resets.
        repeat (400) begin
            rv  = N'($urandom_range(0, (1 << N) - 1));
            dur = $urandom_range(1, 14);
            for (int c = 0; c < dur; c++) begin
                if ($urandom_range(0, 6) == 0) rv = N'($urandom_range(0, (1 << N) - 1));
                step(($urandom_range(0, 199) != 0) ? 1'b1 : 1'b0, rv);
            end
        end
        step(1'b1, 4'b0000);
        @(negedge clk);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL scoreboard_drain: got %0d left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
